// File: rtl/instr_enc_if.sv
// Bundles program control, instruction request, instruction-memory write and
// status signals of the instruction encoder.
interface instr_enc_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_mnem;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ready;
  logic              busy;
  logic              err;
  logic [15:0]       count;

  modport master (
    output start, stop, base_addr, in_valid, in_mnem, in_rs, in_rt, in_rd,
           in_shamt, in_imm, in_target, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata, busy, err, count
  );

  modport slave (
    input  start, stop, base_addr, in_valid, in_mnem, in_rs, in_rt, in_rd,
           in_shamt, in_imm, in_target, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata, busy, err, count
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes MIPS-style instructions and writes them to sequential instruction-memory words.
// Define INSTR_ENC_BRANCH_REL_EN to derive BEQ/BNE offsets from an absolute word-index target.
module instr_encoder #(
  parameter int ADDR_W = 32
) (
  input logic        clk,
  input logic        rst_n,
  instr_enc_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [15:0]       count_q, count_d;
  logic              err_q, err_d;
  logic              we_q, ready_q, busy_q;
  logic [15:0]       br_imm_s;
  logic [32:0]       enc_s;

  // Returns {legal, word}; an illegal mnemonic yields legal=0.
  function automatic logic [32:0] encode(
    input logic [4:0]  mnem, rs, rt, rd, shamt,
    input logic [15:0] imm, br_imm,
    input logic [25:0] target
  );
    logic [32:0] res;
    res = {1'b1, 32'h0000_0000};
    case (mnem)
      5'd0:    res[31:0] = {6'h00, rs, rt, rd, 5'h00, 6'h20};
      5'd1:    res[31:0] = {6'h00, rs, rt, rd, 5'h00, 6'h22};
      5'd2:    res[31:0] = {6'h00, rs, rt, rd, 5'h00, 6'h21};
      5'd3:    res[31:0] = {6'h00, rs, rt, rd, 5'h00, 6'h23};
      5'd4:    res[31:0] = {6'h00, 5'h00, rt, rd, shamt, 6'h00};
      5'd5:    res[31:0] = {6'h00, 5'h00, rt, rd, shamt, 6'h02};
      5'd6:    res[31:0] = {6'h00, rs, rt, rd, 5'h00, 6'h2A};
      5'd7:    res[31:0] = {6'h00, rs, rt, rd, 5'h00, 6'h24};
      5'd8:    res[31:0] = {6'h23, rs, rt, imm};
      5'd9:    res[31:0] = {6'h2B, rs, rt, imm};
      5'd10:   res[31:0] = {6'h04, rs, rt, br_imm};
      5'd11:   res[31:0] = {6'h0D, rs, rt, imm};
      5'd12:   res[31:0] = {6'h0F, 5'h00, rt, imm};
      5'd13:   res[31:0] = {6'h05, rs, rt, br_imm};
      5'd14:   res[31:0] = {6'h02, target};
      5'd15:   res[31:0] = {6'h0A, rs, rt, imm};
      5'd16:   res[31:0] = {6'h08, rs, rt, imm};
      default: res = {1'b0, 32'h0000_0000};
    endcase
    return res;
  endfunction

`ifdef INSTR_ENC_BRANCH_REL_EN
  // Offset is relative to the word after the branch; only the low 16 bits survive.
  assign br_imm_s = bus.in_target[15:0] - addr_q[17:2] - 16'd1;
`else
  assign br_imm_s = bus.in_imm;
`endif

  assign enc_s = encode(bus.in_mnem, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt,
                        bus.in_imm, br_imm_s, bus.in_target);

  // Next-state and datapath updates for the IDLE/RUN/WRITE sequencer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d  = bus.base_addr;
          count_d = 16'd0;
          err_d   = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.in_valid) begin
          if (enc_s[32]) begin
            wdata_d = enc_s[31:0];
            state_d = WRITE;
          end else begin
            err_d   = 1'b1;
          end
        end else begin
          state_d = RUN;
        end
      end
      WRITE: begin
        if (bus.imem_ready) begin
          addr_d  = addr_q + ADDR_W'(4);
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          state_d = RUN;
        end else begin
          state_d = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers; outputs follow the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= 32'h0000_0000;
      count_q <= 16'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= (state_d == WRITE);
      ready_q <= (state_d == RUN);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
  assign bus.count      = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder using an expected-write scoreboard queue.
// Branch expectations follow INSTR_ENC_BRANCH_REL_EN when it is defined for the build.
module tb_instr_encoder;
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [4:0]  m;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [25:0] tgt;
  } instr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_enc_if #(.ADDR_W(ADDR_W)) bus ();
  instr_encoder #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] addr_m;
  logic [15:0] count_m;

  function automatic instr_t mk(input int m, rs, rt, rd, sh, input logic [15:0] imm,
                                input logic [25:0] tgt);
    mk = {5'(m), 5'(rs), 5'(rt), 5'(rd), 5'(sh), imm, tgt};
  endfunction

  function automatic logic [31:0] model(input instr_t t, input logic [31:0] addr);
    logic [15:0] bimm;
`ifdef INSTR_ENC_BRANCH_REL_EN
    logic [31:0] rel;
    rel  = {6'd0, t.tgt} - (addr >> 2) - 32'd1;
    bimm = rel[15:0];
`else
    bimm = t.imm;
`endif
    case (t.m)
      5'd0:    model = {6'h00, t.rs, t.rt, t.rd, 5'd0, 6'h20};
      5'd1:    model = {6'h00, t.rs, t.rt, t.rd, 5'd0, 6'h22};
      5'd2:    model = {6'h00, t.rs, t.rt, t.rd, 5'd0, 6'h21};
      5'd3:    model = {6'h00, t.rs, t.rt, t.rd, 5'd0, 6'h23};
      5'd4:    model = {6'h00, 5'd0, t.rt, t.rd, t.sh, 6'h00};
      5'd5:    model = {6'h00, 5'd0, t.rt, t.rd, t.sh, 6'h02};
      5'd6:    model = {6'h00, t.rs, t.rt, t.rd, 5'd0, 6'h2A};
      5'd7:    model = {6'h00, t.rs, t.rt, t.rd, 5'd0, 6'h24};
      5'd8:    model = {6'h23, t.rs, t.rt, t.imm};
      5'd9:    model = {6'h2B, t.rs, t.rt, t.imm};
      5'd10:   model = {6'h04, t.rs, t.rt, bimm};
      5'd11:   model = {6'h0D, t.rs, t.rt, t.imm};
      5'd12:   model = {6'h0F, 5'd0, t.rt, t.imm};
      5'd13:   model = {6'h05, t.rs, t.rt, bimm};
      5'd14:   model = {6'h02, t.tgt};
      5'd15:   model = {6'h0A, t.rs, t.rt, t.imm};
      5'd16:   model = {6'h08, t.rs, t.rt, t.imm};
      default: model = 32'h0;
    endcase
  endfunction

  task automatic drive_idle();
    bus.start = 1'b0; bus.stop = 1'b0; bus.base_addr = 32'h0;
    bus.in_valid = 1'b0; bus.in_mnem = 5'd0; bus.in_rs = 5'd0; bus.in_rt = 5'd0;
    bus.in_rd = 5'd0; bus.in_shamt = 5'd0; bus.in_imm = 16'h0; bus.in_target = 26'h0;
    bus.imem_ready = 1'b1;
  endtask

  task automatic do_start(input logic [31:0] base);
    @(negedge clk);
    bus.base_addr = base;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    addr_m  = base;
    count_m = 16'd0;
  endtask

  // Presents one request and holds it until the handshake edge; returns just after that edge.
  task automatic issue(input instr_t t);
    int n;
    bus.in_mnem = t.m; bus.in_rs = t.rs; bus.in_rt = t.rt; bus.in_rd = t.rd;
    bus.in_shamt = t.sh; bus.in_imm = t.imm; bus.in_target = t.tgt;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL issue_timeout in_ready got %b want 1", bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_we(output bit ok);
    int n;
    n = 0;
    while (bus.imem_we !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 20);
  endtask

  task automatic test_reset();
    logic [83:0] got;
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    got = {bus.imem_we, bus.in_ready, bus.busy, bus.err, bus.imem_addr, bus.imem_wdata, bus.count};
    checks++;
    if (got !== 84'h0) begin
      errors++; $display("FAIL reset_state got %h want 0", got);
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.busy, bus.imem_we} !== 3'b000) begin
      errors++; $display("FAIL idle_needs_start got %b want 000", {bus.in_ready, bus.busy, bus.imem_we});
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_add();
    logic [63:0] e;
    do_start(32'h100);
    checks++;
    if ({bus.busy, bus.in_ready, bus.err, bus.imem_addr, bus.count} !== {3'b110, 32'h100, 16'd0}) begin
      errors++; $display("FAIL start_state got %h want %h",
        {bus.busy, bus.in_ready, bus.err, bus.imem_addr, bus.count}, {3'b110, 32'h100, 16'd0});
    end
    exp_q.push_back({32'h100, 32'h00221820});
    issue(mk(0, 1, 2, 3, 0, 16'h0, 26'h0));
    checks++;
    if (bus.imem_we !== 1'b1) begin
      errors++; $display("FAIL add_latency imem_we got %b want 1", bus.imem_we);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({bus.imem_addr, bus.imem_wdata, bus.in_ready} !== {e, 1'b0}) begin
      errors++; $display("FAIL add_write got %h want %h", {bus.imem_addr, bus.imem_wdata, bus.in_ready}, {e, 1'b0});
    end
    @(negedge clk);
    checks++;
    if ({bus.imem_addr, bus.count, bus.imem_we, bus.in_ready} !== {32'h104, 16'd1, 2'b01}) begin
      errors++; $display("FAIL add_advance got %h want %h",
        {bus.imem_addr, bus.count, bus.imem_we, bus.in_ready}, {32'h104, 16'd1, 2'b01});
    end
    addr_m = 32'h104; count_m = 16'd1;
  endtask

  task automatic test_encode();
    instr_t tbl[$];
    logic [63:0] e;
    bit ok;
    tbl = '{mk(8, 29, 8, 0, 0, 16'h0004, 26'h0), mk(4, 7, 2, 9, 4, 16'h0, 26'h0),
            mk(5, 3, 6, 10, 31, 16'h0, 26'h0), mk(1, 4, 5, 6, 3, 16'h0, 26'h0),
            mk(2, 8, 9, 10, 1, 16'h0, 26'h0), mk(3, 11, 12, 13, 2, 16'h0, 26'h0),
            mk(6, 14, 15, 16, 0, 16'h0, 26'h0), mk(7, 17, 18, 19, 7, 16'h0, 26'h0),
            mk(12, 9, 3, 0, 0, 16'hABCD, 26'h0), mk(14, 0, 0, 0, 0, 16'h0, 26'h1234567),
            mk(15, 2, 3, 0, 0, 16'h8001, 26'h0), mk(13, 1, 2, 0, 0, 16'h0020, 26'h40)};
    foreach (tbl[i]) begin
      exp_q.push_back({addr_m, model(tbl[i], addr_m)});
      issue(tbl[i]);
      @(negedge clk);
      wait_we(ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || {bus.imem_addr, bus.imem_wdata} !== e) begin
        errors++; $display("FAIL encode_%0d got %h want %h", i, {bus.imem_addr, bus.imem_wdata}, e);
      end
      if (i == 0) begin
        checks++;
        if (bus.imem_wdata !== 32'h8FA80004) begin
          errors++; $display("FAIL lw_word got %h want 8fa80004", bus.imem_wdata);
        end
      end
      @(negedge clk);
      addr_m += 32'd4; count_m += 16'd1;
      checks++;
      if ({bus.imem_addr, bus.count} !== {addr_m, count_m}) begin
        errors++; $display("FAIL encode_adv_%0d got %h want %h", i, {bus.imem_addr, bus.count}, {addr_m, count_m});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] e;
    bus.imem_ready = 1'b0;
    exp_q.push_back({addr_m, 32'hAC641234});
    issue(mk(9, 3, 4, 0, 0, 16'h1234, 26'h0));
    e = exp_q.pop_front();
    bus.stop = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.imem_we, bus.in_ready, bus.imem_addr, bus.imem_wdata} !== {2'b10, e}) begin
        errors++; $display("FAIL stall_%0d got %h want %h", c,
          {bus.imem_we, bus.in_ready, bus.imem_addr, bus.imem_wdata}, {2'b10, e});
      end
    end
    bus.stop = 1'b0;
    bus.imem_ready = 1'b1;
    @(negedge clk);
    addr_m += 32'd4; count_m += 16'd1;
    checks++;
    if ({bus.imem_we, bus.busy, bus.imem_addr, bus.count} !== {2'b01, addr_m, count_m}) begin
      errors++; $display("FAIL stall_release got %h want %h",
        {bus.imem_we, bus.busy, bus.imem_addr, bus.count}, {2'b01, addr_m, count_m});
    end
  endtask

  task automatic test_illegal();
    logic [63:0] e;
    bit ok;
    issue(mk(20, 1, 1, 1, 1, 16'h1, 26'h1));
    @(negedge clk);
    checks++;
    if ({bus.imem_we, bus.err, bus.in_ready, bus.imem_addr, bus.count} !== {3'b011, addr_m, count_m}) begin
      errors++; $display("FAIL illegal_drop got %h want %h",
        {bus.imem_we, bus.err, bus.in_ready, bus.imem_addr, bus.count}, {3'b011, addr_m, count_m});
    end
    exp_q.push_back({addr_m, 32'h34A6BEEF});
    issue(mk(11, 5, 6, 0, 0, 16'hBEEF, 26'h0));
    @(negedge clk);
    wait_we(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || {bus.imem_addr, bus.imem_wdata, bus.err} !== {e, 1'b1}) begin
      errors++; $display("FAIL ori_after_illegal got %h want %h", {bus.imem_addr, bus.imem_wdata, bus.err}, {e, 1'b1});
    end
    @(negedge clk);
    addr_m += 32'd4; count_m += 16'd1;
  endtask

  task automatic test_back_to_back();
    instr_t t;
    int n_we;
    t = mk(16, 1, 2, 0, 0, 16'h0005, 26'h0);
    bus.in_mnem = t.m; bus.in_rs = t.rs; bus.in_rt = t.rt; bus.in_imm = t.imm;
    bus.in_valid = 1'b1;
    n_we = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.imem_we === 1'b1) begin
        n_we++;
        checks++;
        if ({bus.imem_addr, bus.imem_wdata} !== {addr_m, model(t, addr_m)}) begin
          errors++; $display("FAIL b2b_word got %h want %h", {bus.imem_addr, bus.imem_wdata}, {addr_m, model(t, addr_m)});
        end
        addr_m += 32'd4; count_m += 16'd1;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (n_we != 4) begin
      errors++; $display("FAIL b2b_rate writes got %0d want 4", n_we);
    end
    @(negedge clk);
    checks++;
    if ({bus.imem_addr, bus.count} !== {addr_m, count_m}) begin
      errors++; $display("FAIL b2b_count got %h want %h", {bus.imem_addr, bus.count}, {addr_m, count_m});
    end
  endtask

  task automatic test_stop_start();
    bus.start = 1'b1;
    bus.base_addr = 32'hDEAD0000;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if ({bus.busy, bus.imem_addr, bus.count} !== {1'b1, addr_m, count_m}) begin
      errors++; $display("FAIL start_ignored got %h want %h", {bus.busy, bus.imem_addr, bus.count}, {1'b1, addr_m, count_m});
    end
    bus.in_mnem = 5'd0;
    bus.stop = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.in_ready, bus.imem_we, bus.count} !== {3'b000, count_m}) begin
      errors++; $display("FAIL stop_priority got %h want %h", {bus.busy, bus.in_ready, bus.imem_we, bus.count}, {3'b000, count_m});
    end
  endtask

  task automatic test_branch();
    instr_t seq[3];
    logic [63:0] e;
    logic [31:0] want;
    bit ok;
    do_start(32'h0);
    checks++;
    if ({bus.err, bus.count, bus.imem_addr} !== {1'b0, 16'd0, 32'h0}) begin
      errors++; $display("FAIL start_clears got %h want 0", {bus.err, bus.count, bus.imem_addr});
    end
`ifdef INSTR_ENC_BRANCH_REL_EN
    want = 32'h1022FFFD;
`else
    want = 32'h10220010;
`endif
    seq[0] = mk(0, 4, 5, 6, 0, 16'h0, 26'h0);
    seq[1] = mk(2, 7, 8, 9, 0, 16'h0, 26'h0);
    seq[2] = mk(10, 1, 2, 0, 0, 16'h0010, 26'h0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({addr_m, (i == 2) ? want : model(seq[i], addr_m)});
      issue(seq[i]);
      @(negedge clk);
      wait_we(ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || {bus.imem_addr, bus.imem_wdata} !== e) begin
        errors++; $display("FAIL branch_seq_%0d got %h want %h", i, {bus.imem_addr, bus.imem_wdata}, e);
      end
      @(negedge clk);
      addr_m += 32'd4; count_m += 16'd1;
    end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    do_start(32'h40);
    bus.imem_ready = 1'b0;
    issue(mk(0, 1, 2, 3, 0, 16'h0, 26'h0));
    @(negedge clk);
    wait_we(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL midwrite_setup imem_we got %b want 1", bus.imem_we);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.imem_we, bus.busy, bus.in_ready, bus.err, bus.count, bus.imem_addr, bus.imem_wdata} !== 84'h0) begin
      errors++; $display("FAIL midwrite_reset got %h want 0",
        {bus.imem_we, bus.busy, bus.in_ready, bus.err, bus.count, bus.imem_addr, bus.imem_wdata});
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.imem_ready = 1'b1;
    bus.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.in_ready, bus.busy, bus.imem_we} !== 3'b000) begin
      errors++; $display("FAIL post_reset_idle got %b want 000", {bus.in_ready, bus.busy, bus.imem_we});
    end
  endtask

  initial begin
    addr_m = 32'h0;
    count_m = 16'd0;
    test_reset();
    test_add();
    test_encode();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_stop_start();
    test_branch();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
